// File: rtl/intf_mem_ctrl_if.sv
// Memory-side bus between intf_mem_ctrl and the data memory wrapper's interface port.
//  master : driven by intf_mem_ctrl (strobes, word address, write word, length) and
//           receives the read word.
//  slave  : the memory wrapper view of the same signals.
//  Signals: mem_en, mem_wr_en, mem_rd_en, mem_address[DATA_LENGTH], mem_data_in[DATA_LENGTH],
//           mem_data_length[2], mem_data_out[DATA_LENGTH].
interface intf_mem_ctrl_if #(
    parameter int DATA_LENGTH = 32
);
    logic                   mem_en;
    logic                   mem_wr_en;
    logic                   mem_rd_en;
    logic [DATA_LENGTH-1:0] mem_address;
    logic [DATA_LENGTH-1:0] mem_data_in;
    logic [1:0]             mem_data_length;
    logic [DATA_LENGTH-1:0] mem_data_out;

    modport master (
        output mem_en, mem_wr_en, mem_rd_en, mem_address, mem_data_in, mem_data_length,
        input  mem_data_out
    );

    modport slave (
        input  mem_en, mem_wr_en, mem_rd_en, mem_address, mem_data_in, mem_data_length,
        output mem_data_out
    );
endinterface

// File: rtl/intf_mem_ctrl.sv
// intf_mem_ctrl: upstream master of the data memory wrapper's interface-side port.
// Decodes SPI frames (opcode, address, data) into word writes and streaming word reads
// on the shared memory, and owns core_select (RUN hands the memory to the core, HALT
// takes it back). Memory accesses are only issued while core_select is 0.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  spi_cs_active         frame active; low returns to IDLE and drops any partial word
//  rx_valid, rx_byte     received byte strobe and value
//  tx_ack, tx_byte       SPI slave consumed tx_byte / next byte to shift out
//  core_select           1 = core owns memory
//  mem                   memory bus (intf_mem_ctrl_if.master)
module intf_mem_ctrl #(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_ack,
    output logic [7:0]        tx_byte,
    output logic              core_select,
    intf_mem_ctrl_if.master   mem
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CMD      = 4'd1,
        ADDR_HI  = 4'd2,
        ADDR_LO  = 4'd3,
        WR_DATA  = 4'd4,
        RD_REQ   = 4'd5,
        RD_WAIT  = 4'd6,
        RD_SHIFT = 4'd7,
        DISCARD  = 4'd8
    } state_t;

    state_t                    state_q, state_d;
    logic                      is_read_q, is_read_d;
    logic [7:0]                addr_hi_q, addr_hi_d;
    logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;
    logic [1:0]                byte_cnt_q, byte_cnt_d;
    logic [23:0]               word_q, word_d;
    logic [DATA_LENGTH-1:0]    shift_q, shift_d;
    logic [7:0]                tx_byte_q, tx_byte_d;
    logic                      core_select_q, core_select_d;
    logic                      mem_en_q, mem_en_d;
    logic                      mem_wr_en_q, mem_wr_en_d;
    logic                      mem_rd_en_q, mem_rd_en_d;
    logic [ADDRESS_LENGTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_LENGTH-1:0]    mem_data_in_q, mem_data_in_d;
    logic [ADDRESS_LENGTH-1:0] addr_new_s;
    logic [ADDRESS_LENGTH-1:0] addr_inc_s;

    // 16-bit big-endian word address truncated to the implemented index width.
    assign addr_new_s = ADDRESS_LENGTH'({addr_hi_q, rx_byte});
    assign addr_inc_s = addr_q + ADDRESS_LENGTH'(1);

    // Next-state and next-output logic for the frame decoder.
    always_comb begin
        state_d       = state_q;
        is_read_d     = is_read_q;
        addr_hi_d     = addr_hi_q;
        addr_d        = addr_q;
        byte_cnt_d    = byte_cnt_q;
        word_d        = word_q;
        shift_d       = shift_q;
        core_select_d = core_select_q;
        mem_en_d      = 1'b0;
        mem_wr_en_d   = 1'b0;
        mem_rd_en_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;

        if (!spi_cs_active) begin
            // Frame end: abandon everything in flight, partial write words included.
            state_d    = IDLE;
            byte_cnt_d = 2'd0;
            shift_d    = '0;
        end else begin
            case (state_q)
                IDLE, CMD: begin
                    state_d = CMD;
                    if (rx_valid) begin
                        case (rx_byte)
                            8'h02, 8'h03: begin
                                // Memory commands are refused while the core owns the memory.
                                if (core_select_q) begin
                                    state_d = DISCARD;
                                end else begin
                                    is_read_d = rx_byte[0];
                                    state_d   = ADDR_HI;
                                end
                            end
                            8'h0F: begin
                                core_select_d = 1'b1;
                                state_d       = DISCARD;
                            end
                            8'h0E: begin
                                core_select_d = 1'b0;
                                state_d       = DISCARD;
                            end
                            default: state_d = DISCARD;
                        endcase
                    end else begin
                        state_d = CMD;
                    end
                end
                ADDR_HI: begin
                    if (rx_valid) begin
                        addr_hi_d = rx_byte;
                        state_d   = ADDR_LO;
                    end else begin
                        state_d = ADDR_HI;
                    end
                end
                ADDR_LO: begin
                    if (rx_valid) begin
                        addr_d     = addr_new_s;
                        byte_cnt_d = 2'd0;
                        if (is_read_q) begin
                            state_d       = RD_REQ;
                            mem_en_d      = 1'b1;
                            mem_rd_en_d   = 1'b1;
                            mem_address_d = addr_new_s;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end else begin
                        state_d = ADDR_LO;
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_d[7:0]   = rx_byte;
                            2'd1: word_d[15:8]  = rx_byte;
                            2'd2: word_d[23:16] = rx_byte;
                            2'd3: begin
                                // Fourth byte completes the word: one-cycle write pulse.
                                mem_en_d      = 1'b1;
                                mem_wr_en_d   = 1'b1;
                                mem_address_d = addr_q;
                                mem_data_in_d = {rx_byte, word_q};
                                addr_d        = addr_inc_s;
                            end
                            default: word_d = word_q;
                        endcase
                    end else begin
                        byte_cnt_d = byte_cnt_q;
                    end
                end
                RD_REQ: begin
                    // Second cycle of the read keeps rd_en for the wrapper's data hold.
                    mem_rd_en_d = 1'b1;
                    state_d     = RD_WAIT;
                end
                RD_WAIT: begin
                    shift_d    = mem.mem_data_out;
                    byte_cnt_d = 2'd0;
                    state_d    = RD_SHIFT;
                end
                RD_SHIFT: begin
                    if (tx_ack) begin
                        shift_d    = {8'h00, shift_q[DATA_LENGTH-1:8]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Word fully shifted out: fetch the next word (streaming read).
                            addr_d        = addr_inc_s;
                            state_d       = RD_REQ;
                            mem_en_d      = 1'b1;
                            mem_rd_en_d   = 1'b1;
                            mem_address_d = addr_inc_s;
                        end else begin
                            state_d = RD_SHIFT;
                        end
                    end else begin
                        state_d = RD_SHIFT;
                    end
                end
                DISCARD: state_d = DISCARD;
                default: state_d = IDLE;
            endcase
        end

        // Belt-and-braces: no strobe can leave this block while the core owns the memory.
        mem_en_d    = mem_en_d & ~core_select_q;
        mem_wr_en_d = mem_wr_en_d & ~core_select_q;
        mem_rd_en_d = mem_rd_en_d & ~core_select_q;

        // Shift register drains to zero, so tx_byte reads 0 outside a loaded read word.
        tx_byte_d = (state_d == RD_SHIFT) ? shift_d[7:0] : 8'h00;
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            is_read_q     <= 1'b0;
            addr_hi_q     <= 8'h00;
            addr_q        <= '0;
            byte_cnt_q    <= 2'd0;
            word_q        <= 24'h000000;
            shift_q       <= '0;
            tx_byte_q     <= 8'h00;
            core_select_q <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            addr_hi_q     <= addr_hi_d;
            addr_q        <= addr_d;
            byte_cnt_q    <= byte_cnt_d;
            word_q        <= word_d;
            shift_q       <= shift_d;
            tx_byte_q     <= tx_byte_d;
            core_select_q <= core_select_d;
            mem_en_q      <= mem_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign tx_byte             = tx_byte_q;
    assign core_select         = core_select_q;
    assign mem.mem_en          = mem_en_q;
    assign mem.mem_wr_en       = mem_wr_en_q;
    assign mem.mem_rd_en       = mem_rd_en_q;
    assign mem.mem_address     = {{(DATA_LENGTH-ADDRESS_LENGTH){1'b0}}, mem_address_q};
    assign mem.mem_data_in     = mem_data_in_q;
    assign mem.mem_data_length = 2'b11;

endmodule
